// File: rtl/qsn_ctrl_85b.sv
// rtl/qsn_ctrl_85b.sv - QSN select controller for Z=85 circulants, two-stage valid/ready pipeline

module qsn_ctrl_85b #(
    parameter int unsigned SEQ_LEN = 10
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_shift,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  left_sel,
    output logic [6:0]  right_sel,
    output logic [83:0] merge_sel,
    output logic        out_last,
    output logic        err
);

    localparam logic [6:0] Z        = 7'd85;
    localparam logic [7:0] LAST_IDX = 8'(SEQ_LEN - 1);

    logic        s1_valid_q;
    logic [6:0]  s1_e_q;
    logic        s1_last_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic        out_valid_q;
    logic [6:0]  left_q;
    logic [6:0]  right_q;
    logic [83:0] merge_q;
    logic        last_q;

    logic        accept;
    logic        s1_advance;
    logic        illegal;
    logic        grp_last;
    logic [6:0]  e_d;
    logic [6:0]  right_d;
    logic [83:0] merge_d;

    // Stage 2 may take a new entry when it is empty or its current entry leaves this cycle
    assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
    // Gated by rstn so the block never advertises space while held in reset
    assign in_ready   = rstn && (!s1_valid_q || s1_advance);
    assign accept     = in_valid && in_ready;
    assign illegal    = (in_shift > 7'd84);
    assign grp_last   = (cnt_q == LAST_IDX);

    // Effective shift; an out-of-range factor is folded to zero shift
    always_comb begin
        e_d = in_shift;
        if (illegal) begin
            e_d = 7'd0;
        end else if (in_inv && (in_shift != 7'd0)) begin
            e_d = Z - in_shift;
        end
    end

    // Select set derived from the stage-1 effective shift
    always_comb begin
        right_d = (s1_e_q == 7'd0) ? 7'd0 : (Z - s1_e_q);
        merge_d = '0;
        for (int k = 0; k < 84; k++) begin
            merge_d[k] = (8'(k) < (8'd85 - {1'b0, s1_e_q}));
        end
    end

    // Stage 1: capture accepted command with its effective shift and group-end marker
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_e_q     <= 7'd0;
            s1_last_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_e_q     <= e_d;
            s1_last_q  <= grp_last;
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Group position counter and sticky illegal-shift flag
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= grp_last ? 8'd0 : (cnt_q + 8'd1);
            if (illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stage 2: output registers, held while the downstream stalls
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            left_q      <= 7'd0;
            right_q     <= 7'd0;
            merge_q     <= '0;
            last_q      <= 1'b0;
        end else if (s1_advance) begin
            out_valid_q <= 1'b1;
            left_q      <= s1_e_q;
            right_q     <= right_d;
            merge_q     <= merge_d;
            last_q      <= s1_last_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign left_sel  = left_q;
    assign right_sel = right_q;
    assign merge_sel = merge_q;
    assign out_last  = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_qsn_ctrl_85b.sv
// tb/tb_qsn_ctrl_85b.sv - randomized self-checking bench for qsn_ctrl_85b

module tb_qsn_ctrl_85b;

    localparam int SEQ_LEN = 10;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_shift = '0;
    logic        in_inv = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  left_sel;
    logic [6:0]  right_sel;
    logic [83:0] merge_sel;
    logic        out_last;
    logic        err;

    always #5 sys_clk = ~sys_clk;

    qsn_ctrl_85b #(.SEQ_LEN(SEQ_LEN)) dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shift  (in_shift),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .left_sel  (left_sel),
        .right_sel (right_sel),
        .merge_sel (merge_sel),
        .out_last  (out_last),
        .err       (err)
    );

    typedef struct {
        int          s;
        bit          inv;
    } cmd_t;

    typedef struct {
        int          s;
        bit          inv;
        logic [6:0]  l;
        logic [6:0]  r;
        logic [83:0] m;
        logic        last;
    } exp_t;

    cmd_t cmd_q[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   grp = 0;
    int   occ = 0;
    int   lasts_seen = 0;
    bit   err_m = 0;
    bit   sweep_on = 0;
    int   left_of[2][85];

    task automatic chk(input string tag, input logic [83:0] got, input logic [83:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference select set straight from the shift arithmetic
    function automatic exp_t model(input int s, input bit inv, input bit last);
        exp_t x;
        int e;
        if (s > 84)   e = 0;
        else if (inv) e = (85 - s) % 85;
        else          e = s;
        x.s    = s;
        x.inv  = inv;
        x.l    = 7'(e);
        x.r    = 7'((85 - e) % 85);
        x.m    = '0;
        for (int k = 0; k < 84; k++) x.m[k] = (k < 85 - e);
        x.last = last;
        return x;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cmd_q.delete();
        grp   = 0;
        occ   = 0;
        err_m = 0;
    endtask

    task automatic note_accept();
        exp_q.push_back(model(int'(in_shift), in_inv, (grp % SEQ_LEN) == SEQ_LEN - 1));
        grp++;
        occ++;
        if (in_shift > 7'd84) err_m = 1;
    endtask

    task automatic rst(input bit checks);
        @(posedge sys_clk); #1;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'($urandom);
        @(negedge sys_clk);
        if (checks) chk("rst_in_ready", in_ready, 0);
        @(negedge sys_clk);
        if (checks) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_left", left_sel, 0);
            chk("rst_right", right_sel, 0);
            chk("rst_merge", merge_sel, 0);
            chk("rst_last", out_last, 0);
        end
        @(posedge sys_clk); #1;
        rstn = 1'b1; out_ready = 1'b1;
        model_reset();
        @(negedge sys_clk);
        if (checks) chk("post_rst_in_ready", in_ready, 1);
    endtask

    // Drives queued commands with random valid/ready and checks every cycle
    task automatic run(input int p_in, input int p_out, input int budget, input bit partial);
        int          cyc = 0;
        bit          stall_prev = 0;
        logic [6:0]  hl, hr;
        logic [83:0] hm;
        logic        hlast;
        exp_t        x;
        while ((cmd_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(posedge sys_clk); #1;
            if (cmd_q.size() > 0 && $urandom_range(99) < p_in) begin
                in_valid = 1'b1;
                in_shift = 7'(cmd_q[0].s);
                in_inv   = cmd_q[0].inv;
            end else begin
                in_valid = 1'b0;
                in_shift = 7'($urandom);
                in_inv   = 1'($urandom);
            end
            out_ready = ($urandom_range(99) < p_out);
            @(negedge sys_clk);
            chk("in_ready", in_ready, !(occ == 2 && !out_ready));
            chk("err", err, err_m);
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_left", left_sel, hl);
                chk("hold_right", right_sel, hr);
                chk("hold_merge", merge_sel, hm);
                chk("hold_last", out_last, hlast);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("left", left_sel, x.l);
                    chk("right", right_sel, x.r);
                    chk("merge", merge_sel, x.m);
                    chk("last", out_last, x.last);
                    if (sweep_on && x.s <= 84) left_of[x.inv][x.s] = int'(left_sel);
                end
                occ--;
                if (out_last) lasts_seen++;
            end
            stall_prev = out_valid && !out_ready;
            hl = left_sel; hr = right_sel; hm = merge_sel; hlast = out_last;
            if (in_valid && in_ready) begin
                note_accept();
                void'(cmd_q.pop_front());
            end
            cyc++;
        end
        if (!partial) chk("drain_timeout", 84'(cmd_q.size() + exp_q.size()), 0);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t        x;
        logic [83:0] m82;
        int          v[85];
        int          w[85];
        bit          ok;

        rst(1);

        // Forward shift 3 with latency check
        @(posedge sys_clk); #1;
        in_valid = 1'b1; in_shift = 7'd3; in_inv = 1'b0; out_ready = 1'b1;
        @(negedge sys_clk);
        chk("lat_in_ready", in_ready, 1);
        note_accept();
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        @(negedge sys_clk);
        chk("lat1_valid", out_valid, 0);
        @(negedge sys_clk);
        chk("lat2_valid", out_valid, 1);
        m82 = {2'b00, {82{1'b1}}};
        chk("fwd3_left", left_sel, 3);
        chk("fwd3_right", right_sel, 82);
        chk("fwd3_merge", merge_sel, m82);
        x = exp_q.pop_front();
        chk("fwd3_model_merge", merge_sel, x.m);
        occ--;

        // Inverse, zero boundary, illegal then legal commands keeping err sticky
        cmd_q.push_back('{3, 1'b1});
        cmd_q.push_back('{0, 1'b0});
        cmd_q.push_back('{0, 1'b1});
        cmd_q.push_back('{100, 1'b0});
        cmd_q.push_back('{127, 1'b1});
        cmd_q.push_back('{7, 1'b0});
        cmd_q.push_back('{84, 1'b1});
        run(100, 100, 200, 0);

        // Backpressure with random out_ready
        for (int i = 0; i < 10; i++) cmd_q.push_back('{$urandom_range(84), 1'($urandom)});
        run(70, 50, 2000, 0);
        for (int i = 0; i < 40; i++) cmd_q.push_back('{$urandom_range(90), 1'($urandom)});
        run(80, 40, 4000, 0);

        // Grouping: 25 back-to-back commands
        rst(0);
        lasts_seen = 0;
        for (int i = 0; i < 25; i++) cmd_q.push_back('{$urandom_range(84), 1'($urandom)});
        run(100, 100, 500, 0);
        chk("group25_lasts", 84'(lasts_seen), 2);

        // Reset with commands in flight, then a fresh group
        for (int i = 0; i < 8; i++) cmd_q.push_back('{$urandom_range(84), 1'($urandom)});
        run(100, 30, 6, 1);
        rst(1);
        lasts_seen = 0;
        for (int i = 0; i < 10; i++) cmd_q.push_back('{$urandom_range(84), 1'($urandom)});
        run(100, 100, 500, 0);
        chk("regroup_lasts", 84'(lasts_seen), 1);

        // Full sweep both modes, then forward followed by inverse must be identity
        rst(0);
        sweep_on = 1;
        for (int s = 0; s < 85; s++) begin
            cmd_q.push_back('{s, 1'b0});
            cmd_q.push_back('{s, 1'b1});
        end
        run(90, 80, 5000, 0);
        sweep_on = 0;
        for (int s = 0; s < 85; s++) begin
            for (int i = 0; i < 85; i++) v[i] = (i + left_of[0][s]) % 85;
            for (int i = 0; i < 85; i++) w[i] = v[(i + left_of[1][s]) % 85];
            ok = 1;
            for (int i = 0; i < 85; i++) if (w[i] != i) ok = 0;
            chk($sformatf("identity_s%0d", s), ok, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
